// File: rtl/adc_pkg.sv
// Shared types and widths for the ADC conversion sequencer and the SPI controller it drives.
package adc_pkg;

   localparam int ADC_DATA_W    = 32;
   localparam int ADC_REG_CMD_W = 24;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CNV_HIGH = 3'd1,
      CNV_WAIT = 3'd2,
      ACQ      = 3'd3,
      REG_WRT  = 3'd4
   } seq_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/adc_cnv_timer.sv
// Free-running conversion period counter: counts 0..max(period,1)-1 while enabled, tick on the wrap cycle.
module adc_cnv_timer #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [CNT_WIDTH-1:0] period,
   output logic                 tick
);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] period_q, period_d;
   logic [CNT_WIDTH-1:0] per_live;
   logic [CNT_WIDTH-1:0] per_cur;

   // The period is sampled whenever the count sits at 0, so a new value only applies from the next wrap.
   always_comb begin
      per_live = (period == '0) ? CNT_WIDTH'(1) : period;
      per_cur  = (cnt_q == '0) ? per_live : period_q;
      period_d = per_cur;
      tick     = 1'b0;
      cnt_d    = '0;
      if (enable) begin
         if (cnt_q == per_cur - CNT_WIDTH'(1)) begin
            tick  = 1'b1;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         period_q <= CNT_WIDTH'(1);
      end else begin
         cnt_q    <= cnt_d;
         period_q <= period_d;
      end
   end

endmodule

// File: rtl/adc_cnv_sequencer.sv
// Periodic ADC conversion sequencer: CNV pulse, conversion wait, acquisition handoff to the SPI
// controller, single-entry AXI-Stream output, and register-write arbitration between conversions.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for a period tick or a register-write request
// CNV_HIGH | cnv pin high for CNV_HIGH_CYCLES
// CNV_WAIT | ADC converting, CONV_CYCLES before start_acq
// ACQ      | SPI readout running, waiting for acq_done
// REG_WRT  | SPI register write running, waiting for reg_wrt_done
module adc_cnv_sequencer
   import adc_pkg::*;
#(
   parameter int CNT_WIDTH       = 32,
   parameter int CNV_HIGH_CYCLES = 4,
   parameter int CONV_CYCLES     = 72,
   parameter int STAT_WIDTH      = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [CNT_WIDTH-1:0]     cnv_period,
   output logic                     cnv,
   output logic                     start_acq,
   input  logic                     acq_done,
   input  logic [ADC_DATA_W-1:0]    cnv_data,
   output logic                     start_reg_wrt,
   output logic [ADC_REG_CMD_W-1:0] reg_cmd,
   input  logic                     reg_wrt_done,
   input  logic                     reg_wrt_req,
   input  logic [ADC_REG_CMD_W-1:0] reg_wrt_cmd,
   output logic                     reg_wrt_ack,
   output logic [ADC_DATA_W-1:0]    m_axis_tdata,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic [STAT_WIDTH-1:0]    missed_count,
   output logic [STAT_WIDTH-1:0]    overrun_count
);

   localparam int PH_MAX = max_int(CNV_HIGH_CYCLES, CONV_CYCLES);
   localparam int PH_W   = $clog2(PH_MAX + 1);

   seq_state_t               state_q, state_d;
   logic [PH_W-1:0]          ph_q, ph_d;
   logic                     start_acq_q, start_acq_d;
   logic                     start_reg_wrt_q, start_reg_wrt_d;
   logic                     reg_wrt_ack_q, reg_wrt_ack_d;
   logic [ADC_REG_CMD_W-1:0] reg_cmd_q, reg_cmd_d;
   logic [ADC_DATA_W-1:0]    tdata_q, tdata_d;
   logic                     tvalid_q, tvalid_d;
   logic [STAT_WIDTH-1:0]    missed_q, missed_d;
   logic [STAT_WIDTH-1:0]    overrun_q, overrun_d;
   logic                     tick;
   logic                     capture;

   adc_cnv_timer #(
      .CNT_WIDTH(CNT_WIDTH)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .period (cnv_period),
      .tick   (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         ph_q            <= '0;
         start_acq_q     <= 1'b0;
         start_reg_wrt_q <= 1'b0;
         reg_wrt_ack_q   <= 1'b0;
         reg_cmd_q       <= '0;
         tdata_q         <= '0;
         tvalid_q        <= 1'b0;
         missed_q        <= '0;
         overrun_q       <= '0;
      end else begin
         state_q         <= state_d;
         ph_q            <= ph_d;
         start_acq_q     <= start_acq_d;
         start_reg_wrt_q <= start_reg_wrt_d;
         reg_wrt_ack_q   <= reg_wrt_ack_d;
         reg_cmd_q       <= reg_cmd_d;
         tdata_q         <= tdata_d;
         tvalid_q        <= tvalid_d;
         missed_q        <= missed_d;
         overrun_q       <= overrun_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      ph_d            = ph_q;
      start_acq_d     = 1'b0;
      start_reg_wrt_d = 1'b0;
      reg_wrt_ack_d   = 1'b0;
      reg_cmd_d       = reg_cmd_q;
      case (state_q)
         IDLE: begin
            // During the ack cycle the requester still holds req; do not start a second write.
            if (tick) begin
               state_d = CNV_HIGH;
               ph_d    = PH_W'(CNV_HIGH_CYCLES - 1);
            end else if (reg_wrt_req && !reg_wrt_ack_q) begin
               state_d         = REG_WRT;
               reg_cmd_d       = reg_wrt_cmd;
               start_reg_wrt_d = 1'b1;
            end
         end
         CNV_HIGH: begin
            if (ph_q == '0) begin
               state_d = CNV_WAIT;
               ph_d    = PH_W'(CONV_CYCLES - 1);
            end else begin
               ph_d = ph_q - PH_W'(1);
            end
         end
         CNV_WAIT: begin
            if (ph_q == '0) begin
               state_d     = ACQ;
               start_acq_d = 1'b1;
            end else begin
               ph_d = ph_q - PH_W'(1);
            end
         end
         ACQ: begin
            if (acq_done) state_d = IDLE;
         end
         REG_WRT: begin
            if (reg_wrt_done) begin
               state_d       = IDLE;
               reg_wrt_ack_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output holding register and saturating statistics.
   always_comb begin
      capture   = (state_q == ACQ) && acq_done;
      tvalid_d  = tvalid_q && !m_axis_tready;
      tdata_d   = tdata_q;
      overrun_d = overrun_q;
      missed_d  = missed_q;
      if (capture) begin
         if (!tvalid_q || m_axis_tready) begin
            tvalid_d = 1'b1;
            tdata_d  = cnv_data;
         end else if (overrun_q != '1) begin
            overrun_d = overrun_q + STAT_WIDTH'(1);
         end
      end
      if (tick && (state_q != IDLE) && (missed_q != '1)) begin
         missed_d = missed_q + STAT_WIDTH'(1);
      end
   end

   always_comb begin
      cnv           = (state_q == CNV_HIGH);
      start_acq     = start_acq_q;
      start_reg_wrt = start_reg_wrt_q;
      reg_wrt_ack   = reg_wrt_ack_q;
      reg_cmd       = reg_cmd_q;
      m_axis_tdata  = tdata_q;
      m_axis_tvalid = tvalid_q;
      missed_count  = missed_q;
      overrun_count = overrun_q;
   end

endmodule

// File: tb/tb_adc_cnv_sequencer.sv
// Bench for adc_cnv_sequencer: table-driven scenarios and randomized runs against an event-time
// reference model, plus hand sequences for register writes, arbitration and mid-operation reset.
module tb_adc_cnv_sequencer;

   localparam int CNV_HI  = 4;
   localparam int CONV    = 72;
   localparam int ACQ_OFS = 1 + CNV_HI + CONV;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [31:0] cnv_period;
   logic        cnv;
   logic        start_acq;
   logic        acq_done;
   logic [31:0] cnv_data;
   logic        start_reg_wrt;
   logic [23:0] reg_cmd;
   logic        reg_wrt_done;
   logic        reg_wrt_req;
   logic [23:0] reg_wrt_cmd;
   logic        reg_wrt_ack;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic [15:0] missed_count;
   logic [15:0] overrun_count;

   always #5 clk = ~clk;

   adc_cnv_sequencer #(
      .CNT_WIDTH(32), .CNV_HIGH_CYCLES(CNV_HI), .CONV_CYCLES(CONV), .STAT_WIDTH(16)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .cnv_period(cnv_period),
      .cnv(cnv), .start_acq(start_acq), .acq_done(acq_done), .cnv_data(cnv_data),
      .start_reg_wrt(start_reg_wrt), .reg_cmd(reg_cmd), .reg_wrt_done(reg_wrt_done),
      .reg_wrt_req(reg_wrt_req), .reg_wrt_cmd(reg_wrt_cmd), .reg_wrt_ack(reg_wrt_ack),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .missed_count(missed_count), .overrun_count(overrun_count)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Reference model state: one conversion in flight (tick cycle m_t), one output slot.
   bit          m_active;
   int          m_t, m_dly;
   bit          e_valid;
   logic [31:0] e_data;
   int          e_missed, e_ovr, ph, ofs, delivered;
   int          fixed_dly, tr_from, tr_pct;
   bit          stray;

   typedef struct {
      int period;
      int dly;
      int tr_from;
      int exp_samples;
      int exp_missed;
      int exp_ovr;
   } vec_t;

   task automatic nxt();
      @(negedge clk);
      cyc++;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_active  = 1'b0;
      m_t       = -1000;
      m_dly     = 0;
      e_valid   = 1'b0;
      e_data    = '0;
      e_missed  = 0;
      e_ovr     = 0;
      ph        = 0;
      ofs       = 0;
      delivered = 0;
   endtask

   task automatic do_reset();
      nxt();
      reset         = 1'b1;
      enable        = 1'b0;
      acq_done      = 1'b0;
      reg_wrt_req   = 1'b0;
      reg_wrt_done  = 1'b0;
      reg_wrt_cmd   = '0;
      cnv_data      = '0;
      m_axis_tready = 1'b0;
      repeat (2) nxt();
      reset = 1'b0;
      model_reset();
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_cnv"}, cnv, 0);
      chk({tag, "_start_acq"}, start_acq, 0);
      chk({tag, "_start_reg_wrt"}, start_reg_wrt, 0);
      chk({tag, "_reg_wrt_ack"}, reg_wrt_ack, 0);
      chk({tag, "_tvalid"}, m_axis_tvalid, 0);
      chk({tag, "_tdata"}, m_axis_tdata, 0);
      chk({tag, "_missed"}, missed_count, 0);
      chk({tag, "_overrun"}, overrun_count, 0);
   endtask

   // One clock of the model-checked run: compare outputs, drive inputs, advance the model.
   task automatic run_cycle(input bit en_i);
      int peff;
      bit tick, act0, done_ev, old_v, exp_cnv, exp_sa;
      nxt();
      exp_cnv = m_active && (cyc >= m_t + 1) && (cyc <= m_t + CNV_HI);
      exp_sa  = m_active && (cyc == m_t + ACQ_OFS);
      chk("cnv", cnv, exp_cnv);
      chk("start_acq", start_acq, exp_sa);
      chk("tvalid", m_axis_tvalid, e_valid);
      chk("tdata", m_axis_tdata, e_data);
      chk("missed_count", missed_count, e_missed);
      chk("overrun_count", overrun_count, e_ovr);
      chk("no_start_reg_wrt", start_reg_wrt, 0);
      chk("no_reg_wrt_ack", reg_wrt_ack, 0);

      enable   = en_i;
      cnv_data = $urandom;
      if (tr_from >= 0) m_axis_tready = (ofs >= tr_from);
      else              m_axis_tready = ($urandom_range(99) < tr_pct);
      if (m_active && cyc >= m_t + ACQ_OFS) acq_done = (cyc == m_t + ACQ_OFS + m_dly);
      else                                  acq_done = stray && ($urandom_range(15) == 0);
      if (m_axis_tvalid && m_axis_tready) delivered++;

      peff    = (cnv_period == 0) ? 1 : int'(cnv_period);
      tick    = en_i && ((ph % peff) == peff - 1);
      act0    = m_active;
      if (tick && act0 && e_missed < 65535) e_missed++;
      old_v   = e_valid;
      if (old_v && m_axis_tready) e_valid = 1'b0;
      done_ev = act0 && (cyc >= m_t + ACQ_OFS) && acq_done;
      if (done_ev) begin
         if (!old_v || m_axis_tready) begin
            e_valid = 1'b1;
            e_data  = cnv_data;
         end else if (e_ovr < 65535) begin
            e_ovr++;
         end
         m_active = 1'b0;
      end
      if (tick && !act0) begin
         m_active = 1'b1;
         m_t      = cyc;
         m_dly    = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(60));
      end
      ph = en_i ? ph + 1 : 0;
      ofs++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[3];
      int   sr_first;

      reset = 1'b1; enable = 1'b0; cnv_period = 32'd200; acq_done = 1'b0; cnv_data = '0;
      reg_wrt_done = 1'b0; reg_wrt_req = 1'b0; reg_wrt_cmd = '0; m_axis_tready = 1'b0;
      fixed_dly = -1; tr_from = -1; tr_pct = 100; stray = 1'b0;

      do_reset();
      nxt();
      chk_idle_outputs("reset");
      chk("reset_reg_cmd", reg_cmd, 0);

      // {period, acq delay, tready-from offset, delivered, missed, overrun}
      tbl[0] = '{200, 40, 0,   5,  0,  0};
      tbl[1] = '{50,  10, 0,   11, 10, 0};
      tbl[2] = '{200, 40, 750, 3,  0,  2};
      for (int i = 0; i < 3; i++) begin
         do_reset();
         cnv_period = tbl[i].period;
         fixed_dly  = tbl[i].dly;
         tr_from    = tbl[i].tr_from;
         stray      = 1'b0;
         repeat (1080) run_cycle(1'b1);
         repeat (300)  run_cycle(1'b0);
         chk("tbl_delivered", delivered, tbl[i].exp_samples);
         chk("tbl_missed", missed_count, tbl[i].exp_missed);
         chk("tbl_overrun", overrun_count, tbl[i].exp_ovr);
      end

      // Register write while conversions are disabled; stray acq_done during the write.
      do_reset();
      reg_wrt_cmd = 24'hA51234;
      reg_wrt_req = 1'b1;
      nxt();
      chk("rw_start", start_reg_wrt, 1);
      chk("rw_cmd", reg_cmd, 24'hA51234);
      acq_done = 1'b1;
      nxt();
      acq_done = 1'b0;
      chk("rw_start_one_cycle", start_reg_wrt, 0);
      repeat (3) nxt();
      chk("rw_no_early_ack", reg_wrt_ack, 0);
      chk("rw_stray_acq_tvalid", m_axis_tvalid, 0);
      reg_wrt_done = 1'b1;
      nxt();
      reg_wrt_done = 1'b0;
      chk("rw_ack", reg_wrt_ack, 1);
      nxt();
      reg_wrt_req = 1'b0;
      chk("rw_ack_one_cycle", reg_wrt_ack, 0);
      sr_first = 0;
      for (int i = 0; i < 6; i++) begin
         nxt();
         if (start_reg_wrt) sr_first++;
      end
      chk("rw_no_second_write", sr_first, 0);
      chk("rw_cmd_held", reg_cmd, 24'hA51234);

      // Tick and request in the same IDLE cycle: conversion first, write after acq_done.
      do_reset();
      cnv_period = 32'd20;
      nxt();
      enable = 1'b1;
      sr_first = -1;
      for (int i = 1; i <= 110; i++) begin
         nxt();
         if (i == 19) begin
            reg_wrt_req = 1'b1;
            reg_wrt_cmd = 24'h00C3D2;
         end
         if (i == 20) begin
            chk("arb_cnv_first", cnv, 1);
            enable = 1'b0;
         end
         if (i == 19 + ACQ_OFS) chk("arb_start_acq", start_acq, 1);
         acq_done = (i == 99);
         cnv_data = (i == 99) ? 32'h1357_9BDF : 32'h0;
         if (i == 100) begin
            chk("arb_tvalid", m_axis_tvalid, 1);
            chk("arb_tdata", m_axis_tdata, 32'h1357_9BDF);
         end
         if (start_reg_wrt && sr_first < 0) sr_first = i;
         reg_wrt_done = (i == 105);
         if (i == 106) chk("arb_ack", reg_wrt_ack, 1);
         if (i == 107) reg_wrt_req = 1'b0;
      end
      chk("arb_write_cycle", sr_first, 101);
      chk("arb_cmd", reg_cmd, 24'h00C3D2);
      chk("arb_missed", missed_count, 0);

      // Reset while in CNV_WAIT.
      do_reset();
      cnv_period = 32'd10;
      nxt();
      enable = 1'b1;
      for (int i = 1; i <= 31; i++) begin
         nxt();
         if (i == 12) chk("rst1_pre_cnv", cnv, 1);
         if (i == 30) begin
            chk("rst1_pre_missed", missed_count, 2);
            reset  = 1'b1;
            enable = 1'b0;
         end
         if (i == 31) begin
            reset = 1'b0;
            chk_idle_outputs("rst1");
         end
      end

      // Reset while in ACQ with a held sample, then stray acq_done afterwards.
      do_reset();
      cnv_period = 32'd10;
      nxt();
      enable = 1'b1;
      for (int j = 1; j <= 176; j++) begin
         nxt();
         acq_done = (j == 86) || (j == 172);
         cnv_data = (j == 86) ? 32'hDEAD_BEEF : 32'h5A5A_5A5A;
         if (j == 166) chk("rst2_pre_start_acq", start_acq, 1);
         if (j == 170) begin
            chk("rst2_pre_tvalid", m_axis_tvalid, 1);
            chk("rst2_pre_tdata", m_axis_tdata, 32'hDEAD_BEEF);
            chk("rst2_pre_missed", missed_count, 15);
            reset  = 1'b1;
            enable = 1'b0;
         end
         if (j == 171) begin
            reset = 1'b0;
            chk_idle_outputs("rst2");
         end
         if (j == 176) begin
            chk("rst2_stray_tvalid", m_axis_tvalid, 0);
            chk("rst2_stray_tdata", m_axis_tdata, 0);
            chk("rst2_stray_overrun", overrun_count, 0);
         end
      end

      // Randomized segments: random period, readout latency, backpressure and stray acq_done.
      do_reset();
      fixed_dly = -1;
      tr_from   = -1;
      stray     = 1'b1;
      for (int s = 0; s < 8; s++) begin
         repeat ($urandom_range(150, 1)) run_cycle(1'b0);
         case ($urandom_range(3))
            0:       cnv_period = $urandom_range(3);
            1:       cnv_period = $urandom_range(90, 40);
            2:       cnv_period = $urandom_range(200, 90);
            default: cnv_period = $urandom_range(400, 200);
         endcase
         case ($urandom_range(2))
            0:       tr_pct = 100;
            1:       tr_pct = 60;
            default: tr_pct = 15;
         endcase
         repeat ($urandom_range(1200, 150)) run_cycle(1'b1);
      end
      repeat (200) run_cycle(1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
